// File: rtl/axi_pkg.sv
// Shared AXI4 definitions for the burst master: burst and response
// encodings, the master FSM state type and the 4 KB page size.
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [12:0] PAGE_BYTES = 13'h1000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_AW,
      S_W,
      S_B,
      S_AR,
      S_R,
      S_DONE
   } state_e;

endpackage

// File: rtl/axi_cmd_check.sv
// Combinational legality check for a single-burst command.
// Ports:
//   addr    in  12  page offset of the start address (addr[11:0])
//   len     in  8   AXI len (beats - 1)
//   size    in  3   AXI size (log2 bytes per beat)
//   burst   in  2   AXI burst type
//   illegal out 1   command must not reach the bus
module axi_cmd_check
   import axi_pkg::*;
#(
   parameter int MAX_SIZE = 3
) (
   input  logic [11:0] addr,
   input  logic [7:0]  len,
   input  logic [2:0]  size,
   input  logic [1:0]  burst,
   output logic        illegal
);

   logic [16:0] burst_bytes;
   logic [16:0] end_offs;
   logic [11:0] size_mask;
   logic        wrap_len_ok;

   // 17 bits hold (256 << 7) + 0xFFF, so the page-cross test never wraps.
   assign burst_bytes = (17'(len) + 17'd1) << size;
   assign end_offs    = 17'(addr) + burst_bytes;
   assign size_mask   = (12'd1 << size) - 12'd1;
   assign wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);

   always_comb begin
      illegal = 1'b0;
      if (32'(size) > MAX_SIZE)
         illegal = 1'b1;
      if (burst == 2'b11)
         illegal = 1'b1;
      if (burst == BURST_WRAP && (!wrap_len_ok || (addr & size_mask) != 12'd0))
         illegal = 1'b1;
      if (burst == BURST_INCR && end_offs > 17'(PAGE_BYTES))
         illegal = 1'b1;
      if (burst == BURST_FIXED && len > 8'd15)
         illegal = 1'b1;
   end

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 initiator: one command -> one AW/W/B or AR/R burst, one in flight,
// result reported on the done port.
// Ports:
//   cmd_*   command handshake and burst fields from the local client
//   wr_*    write-beat stream (passed through to the W channel)
//   rd_*    read-beat stream (passed through from the R channel)
//   done_*  completion: direction, worst response, protocol-error flag
//   m_*     master-side AXI4 channels AW, W, B, AR, R
module axi_burst_master
   import axi_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 64,
   parameter int MAX_SIZE = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [7:0]          cmd_len,
   input  logic [2:0]          cmd_size,
   input  logic [1:0]          cmd_burst,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [DATA_W/8-1:0] wr_strb,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic [DATA_W-1:0]   rd_data,
   output logic                rd_last,
   output logic                done_valid,
   input  logic                done_ready,
   output logic                done_write,
   output logic [1:0]          done_resp,
   output logic                done_err,
   output logic                m_awvalid,
   input  logic                m_awready,
   output logic [ADDR_W-1:0]   m_awaddr,
   output logic [7:0]          m_awlen,
   output logic [2:0]          m_awsize,
   output logic [1:0]          m_awburst,
   output logic                m_wvalid,
   input  logic                m_wready,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   output logic                m_wlast,
   input  logic                m_bvalid,
   output logic                m_bready,
   input  logic [1:0]          m_bresp,
   output logic                m_arvalid,
   input  logic                m_arready,
   output logic [ADDR_W-1:0]   m_araddr,
   output logic [7:0]          m_arlen,
   output logic [2:0]          m_arsize,
   output logic [1:0]          m_arburst,
   input  logic                m_rvalid,
   output logic                m_rready,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic [1:0]          m_rresp,
   input  logic                m_rlast
);

   state_e              state_q, state_d;
   logic                write_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [7:0]          len_q;
   logic [2:0]          size_q;
   logic [1:0]          burst_q;
   logic [7:0]          beat_cnt;
   logic [1:0]          resp_q;
   logic                err_q;
   logic                illegal;

   axi_cmd_check #(.MAX_SIZE(MAX_SIZE)) u_cmd_check (
      .addr    (cmd_addr[11:0]),
      .len     (cmd_len),
      .size    (cmd_size),
      .burst   (cmd_burst),
      .illegal (illegal)
   );

   // Address channels carry the latched command; data channels are pass-through.
   assign m_awaddr   = addr_q;
   assign m_awlen    = len_q;
   assign m_awsize   = size_q;
   assign m_awburst  = burst_q;
   assign m_araddr   = addr_q;
   assign m_arlen    = len_q;
   assign m_arsize   = size_q;
   assign m_arburst  = burst_q;
   assign m_wdata    = wr_data;
   assign m_wstrb    = wr_strb;
   assign m_wlast    = (beat_cnt == len_q);
   assign rd_data    = m_rdata;
   assign rd_last    = m_rlast;
   assign done_write = write_q;
   assign done_resp  = resp_q;
   assign done_err   = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      cmd_ready  = 1'b0;
      m_awvalid  = 1'b0;
      m_arvalid  = 1'b0;
      m_wvalid   = 1'b0;
      wr_ready   = 1'b0;
      m_bready   = 1'b0;
      rd_valid   = 1'b0;
      m_rready   = 1'b0;
      done_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid)
               state_d = illegal ? S_DONE : (cmd_write ? S_AW : S_AR);
         end
         S_AW: begin
            m_awvalid = 1'b1;
            if (m_awready) state_d = S_W;
         end
         S_W: begin
            m_wvalid = wr_valid;
            wr_ready = m_wready;
            if (wr_valid && m_wready && m_wlast) state_d = S_B;
         end
         S_B: begin
            m_bready = 1'b1;
            if (m_bvalid) state_d = S_DONE;
         end
         S_AR: begin
            m_arvalid = 1'b1;
            if (m_arready) state_d = S_R;
         end
         S_R: begin
            rd_valid = m_rvalid;
            m_rready = rd_ready;
            if (m_rvalid && rd_ready && m_rlast) state_d = S_DONE;
         end
         S_DONE: begin
            done_valid = 1'b1;
            if (done_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_q  <= 1'b0;
         addr_q   <= '0;
         len_q    <= '0;
         size_q   <= '0;
         burst_q  <= '0;
         beat_cnt <= '0;
         resp_q   <= RESP_OKAY;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (cmd_valid) begin
               write_q  <= cmd_write;
               addr_q   <= cmd_addr;
               len_q    <= cmd_len;
               size_q   <= cmd_size;
               burst_q  <= cmd_burst;
               beat_cnt <= '0;
               resp_q   <= illegal ? RESP_SLVERR : RESP_OKAY;
               err_q    <= illegal;
            end
            S_W: if (wr_valid && m_wready) beat_cnt <= beat_cnt + 8'd1;
            S_B: if (m_bvalid) resp_q <= m_bresp;
            S_R: if (m_rvalid && rd_ready) begin
               beat_cnt <= beat_cnt + 8'd1;
               // Numeric max ranks EXOKAY below SLVERR/DECERR.
               if (m_rresp > resp_q) resp_q <= m_rresp;
               // Early rlast, or the expected final beat arriving without rlast
               // (overrun); the flag is sticky for any further beats.
               if (m_rlast ? (beat_cnt != len_q) : (beat_cnt == len_q))
                  err_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master; the bench plays the AXI slave and client.
module tb_axi_burst_master;

   logic        clk, rst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [2:0]  cmd_size;
   logic [1:0]  cmd_burst;
   logic        wr_valid, wr_ready;
   logic [63:0] wr_data;
   logic [7:0]  wr_strb;
   logic        rd_valid, rd_ready, rd_last;
   logic [63:0] rd_data;
   logic        done_valid, done_ready, done_write, done_err;
   logic [1:0]  done_resp;
   logic        m_awvalid, m_awready;
   logic [31:0] m_awaddr;
   logic [7:0]  m_awlen;
   logic [2:0]  m_awsize;
   logic [1:0]  m_awburst;
   logic        m_wvalid, m_wready, m_wlast;
   logic [63:0] m_wdata;
   logic [7:0]  m_wstrb;
   logic        m_bvalid, m_bready;
   logic [1:0]  m_bresp;
   logic        m_arvalid, m_arready;
   logic [31:0] m_araddr;
   logic [7:0]  m_arlen;
   logic [2:0]  m_arsize;
   logic [1:0]  m_arburst;
   logic        m_rvalid, m_rready, m_rlast;
   logic [63:0] m_rdata;
   logic [1:0]  m_rresp;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] wmem [4];

   axi_burst_master #(.ADDR_W(32), .DATA_W(64), .MAX_SIZE(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .done_valid(done_valid), .done_ready(done_ready), .done_write(done_write),
      .done_resp(done_resp), .done_err(done_err),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
      .m_awsize(m_awsize), .m_awburst(m_awburst),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_wlast(m_wlast),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
      .m_arsize(m_arsize), .m_arburst(m_arburst),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
      .m_rlast(m_rlast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_cmd(input logic w, input logic [31:0] a, input logic [7:0] l,
                            input logic [2:0] s, input logic [1:0] b);
      int k = 0;
      while (!cmd_ready && k < 50) begin
         tick();
         k++;
      end
      chk("cmd_ready", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic finish_done(input logic w, input logic [1:0] resp, input logic err);
      chk("done_valid", 64'(done_valid), 64'd1);
      chk("done_write", 64'(done_write), 64'(w));
      chk("done_resp", 64'(done_resp), 64'(resp));
      chk("done_err", 64'(done_err), 64'(err));
      chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
      tick();
      chk("done_hold", 64'({done_valid, done_resp, done_err}), 64'({1'b1, resp, err}));
      done_ready = 1'b1;
      tick();
      done_ready = 1'b0;
      chk("done_clr", 64'(done_valid), 64'd0);
      chk("cmd_ready_back", 64'(cmd_ready), 64'd1);
   endtask

   // Address phase (one stall cycle), then nbeats full-rate W beats, then B.
   task automatic wr_burst(input logic [31:0] a, input logic [7:0] l, input int nbeats,
                           input logic [63:0] base, input logic [1:0] bresp);
      chk("awvalid", 64'(m_awvalid), 64'd1);
      chk("aw_fields", 64'({m_awaddr, m_awlen, m_awsize, m_awburst}), 64'({a, l, 3'd3, 2'b01}));
      tick();
      chk("awvalid_hold", 64'(m_awvalid), 64'd1);
      m_awready = 1'b1;
      tick();
      m_awready = 1'b0;
      chk("awvalid_clr", 64'(m_awvalid), 64'd0);
      for (int i = 0; i < nbeats; i++) begin
         wr_valid = 1'b1; wr_data = base + 64'(i); wr_strb = 8'hFF; m_wready = 1'b1;
         #1;
         chk("w_hs", 64'({m_wvalid, wr_ready, m_wstrb}), 64'({1'b1, 1'b1, 8'hFF}));
         chk("wdata", m_wdata, base + 64'(i));
         chk("wlast", 64'(m_wlast), 64'(i == nbeats - 1));
         if (i < 4) wmem[i] = m_wdata;
         tick();
      end
      wr_valid = 1'b0;
      #1;
      chk("b_state", 64'({m_bready, wr_ready, m_wvalid}), 64'({1'b1, 1'b0, 1'b0}));
      m_wready = 1'b0;
      m_bvalid = 1'b1; m_bresp = bresp;
      tick();
      m_bvalid = 1'b0;
   endtask

   // Slave returns nbeats with rlast on beat last_idx; resps holds 2 bits per beat.
   task automatic rd_burst(input logic [31:0] a, input logic [7:0] l, input int nbeats,
                           input int last_idx, input logic [31:0] resps,
                           input logic [63:0] base, input logic use_w);
      logic [63:0] exp_d;
      chk("arvalid", 64'(m_arvalid), 64'd1);
      chk("ar_fields", 64'({m_araddr, m_arlen}), 64'({a, l}));
      m_arready = 1'b1;
      tick();
      m_arready = 1'b0;
      chk("arvalid_clr", 64'(m_arvalid), 64'd0);
      rd_ready = 1'b1;
      for (int i = 0; i < nbeats; i++) begin
         exp_d = use_w ? 64'hA0 + 64'(i) : base + 64'(i);
         m_rvalid = 1'b1;
         m_rdata  = use_w ? wmem[i] : base + 64'(i);
         m_rresp  = resps[2*i +: 2];
         m_rlast  = (i == last_idx);
         #1;
         chk("r_hs", 64'({rd_valid, m_rready}), 64'({1'b1, 1'b1}));
         chk("rdata", rd_data, exp_d);
         chk("rlast", 64'(rd_last), 64'(i == last_idx));
         tick();
      end
      m_rvalid = 1'b0; m_rlast = 1'b0; rd_ready = 1'b0;
   endtask

   task automatic illegal_cmd(input string tag, input logic w, input logic [31:0] a,
                              input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
      start_cmd(w, a, l, s, b);
      chk(tag, 64'({done_valid, m_awvalid, m_arvalid}), 64'({1'b1, 1'b0, 1'b0}));
      finish_done(w, 2'b10, 1'b1);
   endtask

   initial begin
      int sent;
      int cyc;
      rst_n = 1'b0;
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0; cmd_burst = 0;
      wr_valid = 0; wr_data = 0; wr_strb = 0; rd_ready = 0; done_ready = 0;
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
      m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0;
      repeat (3) tick();
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_valids", 64'({m_awvalid, m_wvalid, m_arvalid, rd_valid, done_valid}), 64'd0);
      chk("rst_readies", 64'({m_bready, m_rready, wr_ready}), 64'd0);
      chk("rst_done", 64'({done_resp, done_err, done_write}), 64'd0);
      rst_n = 1'b1;
      tick();

      // Write INCR 0x100 len 3, then read it back.
      start_cmd(1'b1, 32'h100, 8'd3, 3'd3, 2'b01);
      wr_burst(32'h100, 8'd3, 4, 64'hA0, 2'b00);
      finish_done(1'b1, 2'b00, 1'b0);
      start_cmd(1'b0, 32'h100, 8'd3, 3'd3, 2'b01);
      rd_burst(32'h100, 8'd3, 4, 3, 32'h0, 64'h0, 1'b1);
      finish_done(1'b0, 2'b00, 1'b0);

      // Illegal commands: done one cycle after accept, no bus activity.
      illegal_cmd("ill_4k", 1'b1, 32'hFF8, 8'd1, 3'd3, 2'b01);
      illegal_cmd("ill_4k_long", 1'b0, 32'h808, 8'd255, 3'd3, 2'b01);
      illegal_cmd("ill_wrap_len", 1'b0, 32'h100, 8'd2, 3'd3, 2'b10);
      illegal_cmd("ill_wrap_align", 1'b0, 32'h104, 8'd3, 3'd3, 2'b10);
      illegal_cmd("ill_size", 1'b0, 32'h0, 8'd0, 3'd4, 2'b01);
      illegal_cmd("ill_burst", 1'b0, 32'h0, 8'd0, 3'd0, 2'b11);
      illegal_cmd("ill_fixed", 1'b0, 32'h0, 8'd16, 3'd0, 2'b00);

      // INCR ending exactly on the page boundary is legal.
      start_cmd(1'b0, 32'hFF0, 8'd1, 3'd3, 2'b01);
      rd_burst(32'hFF0, 8'd1, 2, 1, 32'h0, 64'h5000, 1'b0);
      finish_done(1'b0, 2'b00, 1'b0);

      // Worst response kept: beats 0,2,0,0 -> SLVERR.
      start_cmd(1'b0, 32'h200, 8'd3, 3'd3, 2'b01);
      rd_burst(32'h200, 8'd3, 4, 3, {24'h0, 2'b00, 2'b00, 2'b10, 2'b00}, 64'h6000, 1'b0);
      finish_done(1'b0, 2'b10, 1'b0);

      // DECERR then EXOKAY: DECERR stays.
      start_cmd(1'b0, 32'h200, 8'd1, 3'd3, 2'b01);
      rd_burst(32'h200, 8'd1, 2, 1, {28'h0, 2'b01, 2'b11}, 64'h6100, 1'b0);
      finish_done(1'b0, 2'b11, 1'b0);

      // Early rlast on beat 2 of 4.
      start_cmd(1'b0, 32'h300, 8'd3, 3'd3, 2'b01);
      rd_burst(32'h300, 8'd3, 2, 1, 32'h0, 64'h7000, 1'b0);
      finish_done(1'b0, 2'b00, 1'b1);

      // Overrun: len 1 but rlast only on beat 3.
      start_cmd(1'b0, 32'h300, 8'd1, 3'd3, 2'b01);
      rd_burst(32'h300, 8'd1, 3, 2, 32'h0, 64'h7100, 1'b0);
      finish_done(1'b0, 2'b00, 1'b1);

      // Backpressured write len 15: 16 beats in order.
      start_cmd(1'b1, 32'h400, 8'd15, 3'd3, 2'b01);
      chk("bp_awvalid", 64'(m_awvalid), 64'd1);
      m_awready = 1'b1;
      tick();
      m_awready = 1'b0;
      sent = 0;
      cyc = 0;
      while (sent < 16 && cyc < 500) begin
         wr_valid = 1'($urandom_range(0, 1));
         m_wready = 1'($urandom_range(0, 1));
         wr_data  = 64'h1000 + 64'(sent);
         wr_strb  = 8'h0F;
         #1;
         if (wr_valid && m_wready) begin
            chk("bp_wdata", m_wdata, 64'h1000 + 64'(sent));
            chk("bp_wlast", 64'(m_wlast), 64'(sent == 15));
            sent++;
         end
         tick();
         cyc++;
      end
      chk("bp_beats", 64'(sent), 64'd16);
      wr_valid = 1'b0; m_wready = 1'b0;
      #1;
      chk("bp_bready", 64'(m_bready), 64'd1);
      m_bvalid = 1'b1; m_bresp = 2'b00;
      tick();
      m_bvalid = 1'b0;
      finish_done(1'b1, 2'b00, 1'b0);

      // Asynchronous reset in the middle of a write burst.
      start_cmd(1'b1, 32'h500, 8'd3, 3'd3, 2'b01);
      m_awready = 1'b1;
      tick();
      m_awready = 1'b0;
      wr_valid = 1'b1; m_wready = 1'b1; wr_data = 64'hBEEF;
      tick();
      chk("mid_w", 64'(m_wvalid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_valids", 64'({m_awvalid, m_wvalid, m_arvalid, rd_valid, done_valid}), 64'd0);
      chk("arst_ready", 64'({cmd_ready, wr_ready, m_bready}), 64'({1'b1, 1'b0, 1'b0}));
      wr_valid = 1'b0; m_wready = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst", 64'({cmd_ready, done_valid}), 64'({1'b1, 1'b0}));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
